// File: rtl/ov7670_capture_dec.sv
// OV7670 pixel-bus capture with decimation, clipping and ping-pong banking.
// Optional CAPTURE_STATS_EN builds per-frame line/pixel statistics.
module ov7670_capture_dec #(
  parameter int c_img_cols     = 160,
  parameter int c_img_rows     = 120,
  parameter int c_decim        = 1,
  parameter int c_nb_buf_red   = 4,
  parameter int c_nb_buf_green = 4,
  parameter int c_nb_buf_blue  = 4,
  parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green
                                 + c_nb_buf_blue,
  parameter int c_nb_img_pxls  = $clog2(c_img_cols * c_img_rows)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pclk,
  input  logic                     href,
  input  logic                     vsync,
  input  logic [7:0]               data,
  input  logic [1:0]               mode,
  input  logic                     swap_r_b,
  output logic [c_nb_img_pxls-1:0] addr,
  output logic [c_nb_buf-1:0]      dout,
  output logic                     we,
  output logic                     bank,
  output logic                     newframe,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [11:0]              stat_line_pxls,
  output logic [9:0]               stat_lines
);

  localparam int AW = c_nb_img_pxls;
  localparam int RW = $clog2(c_img_rows + 1);
  localparam int NR = c_nb_buf_red;
  localparam int NG = c_nb_buf_green;
  localparam int NB = c_nb_buf_blue;

  localparam logic [11:0]   COLS    = 12'(c_img_cols);
  localparam logic [RW-1:0] ROWS    = RW'(c_img_rows);
  localparam logic [RW-1:0] ROWS_M1 = RW'(c_img_rows - 1);
  localparam logic [11:0]   DM      = 12'(c_decim - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_VBLANK,
    ST_ACTIVE
  } state_t;

  state_t state, state_nx;

  logic [2:0] pc_sr, hr_sr, vs_sr;
  logic [7:0] d1, d2, d3;
  logic       href_q;
  logic       vf, vf_q, nf, prise;
  logic       href_s3;
  logic [7:0] data_s3;

  logic [1:0] mode_r;
  logic       swap_r;
  logic       tog, line_ok;
  logic [7:0] b0_q;
  logic [11:0] in_col;
  logic [9:0]  in_line;
  logic [11:0] out_col;
  logic [RW-1:0] out_row;
  logic [AW-1:0] row_base;

  logic active, hrise, hfall, col_kept, line_kept, in_range, fd_nx;

  // Three-stage synchroniser on every camera pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_sr  <= '0;
      hr_sr  <= '0;
      vs_sr  <= '0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      href_q <= 1'b0;
      vf_q   <= 1'b0;
    end else begin
      pc_sr  <= {pc_sr[1:0], pclk};
      hr_sr  <= {hr_sr[1:0], href};
      vs_sr  <= {vs_sr[1:0], vsync};
      d1     <= data;
      d2     <= d1;
      d3     <= d2;
      href_q <= hr_sr[2];
      vf_q   <= vf;
    end
  end

  assign href_s3 = hr_sr[2];
  assign data_s3 = d3;
  assign prise   = pc_sr[1] & ~pc_sr[2];
  assign vf      = &vs_sr & vsync;
  assign nf      = vf & ~vf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fd_nx    = 1'b0;
    unique case (state)
      ST_WAIT:   if (nf) state_nx = ST_VBLANK;
      ST_VBLANK: if (!vf) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (nf) begin
        state_nx = ST_VBLANK;
        fd_nx    = (in_line != '0);
      end
      default:   state_nx = ST_WAIT;
    endcase
  end

  assign active    = (state == ST_ACTIVE) && !nf;
  assign hrise     = href_s3 && !href_q;
  assign hfall     = !href_s3 && href_q && line_ok;
  assign col_kept  = (in_col & DM) == '0;
  assign line_kept = (in_line & DM[9:0]) == '0;
  assign in_range  = (out_col < COLS) && (out_row < ROWS);

  // Pixel formatting: channels left-aligned to 8 bits, then cut to width
  logic [7:0] r8, g8, b8;
  logic [c_nb_buf-1:0] rgb_w, gray_w, pix_w;

  always_comb begin
    r8 = '0;
    g8 = '0;
    b8 = '0;
    if (mode_r == 2'b00) begin
      r8 = {b0_q[3:0], 4'h0};
      g8 = {data_s3[7:4], 4'h0};
      b8 = {data_s3[3:0], 4'h0};
    end else begin
      r8 = {b0_q[7:3], 3'b000};
      g8 = {b0_q[2:0], data_s3[7:5], 2'b00};
      b8 = {data_s3[4:0], 3'b000};
    end
    if (swap_r)
      rgb_w = {b8[7 -: NR], g8[7 -: NG], r8[7 -: NB]};
    else
      rgb_w = {r8[7 -: NR], g8[7 -: NG], b8[7 -: NB]};
    pix_w = mode_r[1] ? gray_w : rgb_w;
  end

  if (c_nb_buf > 8) begin : g_gray_ext
    assign gray_w = {{(c_nb_buf - 8){1'b0}}, b0_q};
  end else begin : g_gray_cut
    assign gray_w = b0_q[7 -: c_nb_buf];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= '0;
      swap_r     <= 1'b0;
      tog        <= 1'b0;
      line_ok    <= 1'b0;
      b0_q       <= '0;
      in_col     <= '0;
      in_line    <= '0;
      out_col    <= '0;
      out_row    <= '0;
      row_base   <= '0;
      addr       <= '0;
      dout       <= '0;
      we         <= 1'b0;
      bank       <= 1'b0;
      newframe   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      we         <= 1'b0;
      newframe   <= nf;
      frame_done <= fd_nx;
      bank       <= bank ^ frame_done;
      if (nf) begin
        mode_r   <= mode;
        swap_r   <= swap_r_b;
        overflow <= 1'b0;
      end
      if (!active) begin
        tog      <= 1'b0;
        line_ok  <= 1'b0;
        in_col   <= '0;
        in_line  <= '0;
        out_col  <= '0;
        out_row  <= '0;
        row_base <= '0;
      end else if (!href_s3) begin
        tog <= 1'b0;
        if (hfall) begin
          line_ok <= 1'b0;
          in_col  <= '0;
          out_col <= '0;
          if (in_line != '1) in_line <= in_line + 10'd1;
          if (line_kept && out_row < ROWS) begin
            out_row <= out_row + RW'(1);
            if (out_row < ROWS_M1)
              row_base <= row_base + AW'(c_img_cols);
          end
        end
      end else begin
        if (hrise) line_ok <= 1'b1;
        if (prise && line_ok) begin
          if (!tog) begin
            b0_q <= data_s3;
            tog  <= 1'b1;
          end else begin
            tog <= 1'b0;
            if (in_col != '1) in_col <= in_col + 12'd1;
            if (col_kept && line_kept) begin
              if (in_range) begin
                we   <= 1'b1;
                addr <= row_base + AW'(out_col);
                dout <= pix_w;
              end else begin
                overflow <= 1'b1;
              end
              if (out_col != '1) out_col <= out_col + 12'd1;
            end
          end
        end
      end
    end
  end

`ifdef CAPTURE_STATS_EN
  logic [11:0] line_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_max       <= '0;
      stat_line_pxls <= '0;
      stat_lines     <= '0;
    end else begin
      if (nf) begin
        stat_line_pxls <= line_max;
        stat_lines     <= in_line;
      end
      if (!active)
        line_max <= '0;
      else if (hfall && in_col > line_max)
        line_max <= in_col;
    end
  end
`else
  assign stat_line_pxls = '0;
  assign stat_lines     = '0;
`endif

endmodule

// File: tb/tb_ov7670_capture_dec.sv
// Scoreboard bench for ov7670_capture_dec: two instances (decimation 1 and 2)
// share the camera pins; a monitor per instance pops expected writes.
module tb_ov7670_capture_dec;

  localparam int COLS = 16;
  localparam int ROWS = 8;

  logic clk = 1'b0;
  logic rst_n, pclk, href, vsync, swap_r_b;
  logic [7:0] data;
  logic [1:0] mode;

  logic [6:0]  addr1, addr2;
  logic [11:0] dout1, dout2;
  logic we1, we2, bank1, bank2, nfr1, nfr2, fd1, fd2, ovf1, ovf2;
  logic [11:0] slp1, slp2;
  logic [9:0]  sl1, sl2;

  always #10 clk = ~clk;

  ov7670_capture_dec #(.c_img_cols(COLS), .c_img_rows(ROWS), .c_decim(1))
  dut1 (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .href(href), .vsync(vsync),
    .data(data), .mode(mode), .swap_r_b(swap_r_b), .addr(addr1),
    .dout(dout1), .we(we1), .bank(bank1), .newframe(nfr1),
    .frame_done(fd1), .overflow(ovf1), .stat_line_pxls(slp1),
    .stat_lines(sl1)
  );

  ov7670_capture_dec #(.c_img_cols(COLS), .c_img_rows(ROWS), .c_decim(2))
  dut2 (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .href(href), .vsync(vsync),
    .data(data), .mode(mode), .swap_r_b(swap_r_b), .addr(addr2),
    .dout(dout2), .we(we2), .bank(bank2), .newframe(nfr2),
    .frame_done(fd2), .overflow(ovf2), .stat_line_pxls(slp2),
    .stat_lines(sl2)
  );

  typedef struct {
    logic [6:0]  a;
    logic [11:0] d;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int nf_cnt1 = 0, nf_cnt2 = 0, fd_cnt1 = 0, fd_cnt2 = 0;
  int exp_nf = 0, exp_fd = 0;
  bit exp_bank = 1'b0;
  bit eo1 = 1'b0, eo2 = 1'b0;
  int ln = 0;
  int max_np = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL we1_extra: got write @0x%0h want none", addr1);
      end else begin
        e = q1.pop_front();
        chk("addr1", 32'(addr1), 32'(e.a));
        chk("dout1", 32'(dout1), 32'(e.d));
      end
    end
    if (fd1) begin
      fd_cnt1++;
      chk("fd_with_nf1", 32'(nfr1), 32'd1);
    end
    if (nfr1) nf_cnt1++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (we2) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL we2_extra: got write @0x%0h want none", addr2);
      end else begin
        e = q2.pop_front();
        chk("addr2", 32'(addr2), 32'(e.a));
        chk("dout2", 32'(dout2), 32'(e.d));
      end
    end
    if (fd2) begin
      fd_cnt2++;
      chk("fd_with_nf2", 32'(nfr2), 32'd1);
    end
    if (nfr2) nf_cnt2++;
  end

  task automatic send_byte(logic [7:0] b);
    data = b;
    pclk = 1'b0;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic raw_line(int np, logic [7:0] b0, logic [7:0] b1);
    @(negedge clk);
    href = 1'b1;
    for (int p = 0; p < np; p++) begin
      send_byte(b0);
      send_byte(b1);
    end
    pclk = 1'b0;
    repeat (2) @(negedge clk);
    href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic line(int np, logic [7:0] b0, logic [7:0] b1,
                      logic [11:0] ed);
    exp_t x;
    x.d = ed;
    for (int p = 0; p < np; p++) begin
      if (p < COLS && ln < ROWS) begin
        x.a = 7'(ln * COLS + p);
        q1.push_back(x);
      end else begin
        eo1 = 1'b1;
      end
      if (ln % 2 == 0 && p % 2 == 0) begin
        if (p / 2 < COLS && ln / 2 < ROWS) begin
          x.a = 7'((ln / 2) * COLS + p / 2);
          q2.push_back(x);
        end else begin
          eo2 = 1'b1;
        end
      end
    end
    if (np > max_np) max_np = np;
    raw_line(np, b0, b1);
    ln++;
  endtask

  task automatic close_frame(int len, bit abort);
    chk("ovf1_pre", 32'(ovf1), 32'(eo1));
    chk("ovf2_pre", 32'(ovf2), 32'(eo2));
    if (abort) begin
      @(negedge clk);
      href = 1'b1;
      send_byte(8'h9C);
    end
    @(negedge clk);
    vsync = 1'b1;
    repeat (len) @(negedge clk);
    if (abort) begin
      href = 1'b0;
      pclk = 1'b0;
      repeat (6) @(negedge clk);
    end
    vsync = 1'b0;
    repeat (8) @(negedge clk);
    exp_nf++;
    if (ln > 0) begin
      exp_fd++;
      exp_bank = ~exp_bank;
    end
    chk("nf_cnt1", 32'(nf_cnt1), 32'(exp_nf));
    chk("nf_cnt2", 32'(nf_cnt2), 32'(exp_nf));
    chk("fd_cnt1", 32'(fd_cnt1), 32'(exp_fd));
    chk("fd_cnt2", 32'(fd_cnt2), 32'(exp_fd));
    chk("bank1", 32'(bank1), 32'(exp_bank));
    chk("bank2", 32'(bank2), 32'(exp_bank));
    chk("pending1", 32'(q1.size()), 32'd0);
    chk("pending2", 32'(q2.size()), 32'd0);
    chk("ovf1_clr", 32'(ovf1), 32'd0);
    chk("ovf2_clr", 32'(ovf2), 32'd0);
`ifdef CAPTURE_STATS_EN
    chk("stat_pxls1", 32'(slp1), 32'(max_np));
    chk("stat_lines1", 32'(sl1), 32'(ln));
    chk("stat_pxls2", 32'(slp2), 32'(max_np));
    chk("stat_lines2", 32'(sl2), 32'(ln));
`else
    chk("stat_pxls1", 32'(slp1), 32'd0);
    chk("stat_lines1", 32'(sl1), 32'd0);
`endif
    ln = 0;
    max_np = 0;
    eo1 = 1'b0;
    eo2 = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_we1"}, 32'(we1), 32'd0);
    chk({tag, "_addr1"}, 32'(addr1), 32'd0);
    chk({tag, "_dout1"}, 32'(dout1), 32'd0);
    chk({tag, "_bank1"}, 32'(bank1), 32'd0);
    chk({tag, "_nf1"}, 32'(nfr1), 32'd0);
    chk({tag, "_fd1"}, 32'(fd1), 32'd0);
    chk({tag, "_ovf1"}, 32'(ovf1), 32'd0);
    chk({tag, "_slp1"}, 32'(slp1), 32'd0);
    chk({tag, "_sl1"}, 32'(sl1), 32'd0);
    chk({tag, "_addr2"}, 32'(addr2), 32'd0);
    chk({tag, "_bank2"}, 32'(bank2), 32'd0);
    chk({tag, "_we2"}, 32'(we2), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    pclk     = 1'b0;
    href     = 1'b0;
    vsync    = 1'b0;
    data     = 8'h00;
    mode     = 2'b00;
    swap_r_b = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First vsync leaves WAIT_FRAME; RGB444 for the next frame
    close_frame(6, 1'b0);
    for (int l = 0; l < ROWS; l++) line(COLS, 8'h0A, 8'hBC, 12'hABC);

    // 4-clk pulse is accepted; RGB565 with red/blue swapped next
    mode     = 2'b01;
    swap_r_b = 1'b1;
    close_frame(4, 1'b0);
    line(COLS, 8'hF8, 8'h1F, 12'hF0F);
    line(COLS, 8'hF8, 8'h00, 12'h00F);
    line(COLS, 8'h07, 8'hE0, 12'h0F0);

    mode     = 2'b00;
    swap_r_b = 1'b0;
    close_frame(6, 1'b0);
    line(20, 8'h0A, 8'hBC, 12'hABC);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_nf1", 32'(nf_cnt1), 32'(exp_nf));
    chk("glitch_nf2", 32'(nf_cnt2), 32'(exp_nf));
    line(COLS, 8'h01, 8'h23, 12'h123);
    for (int l = 0; l < 8; l++) line(2, 8'h04, 8'h56, 12'h456);

    mode = 2'b10;
    close_frame(6, 1'b0);
    line(4, 8'h9C, 8'h55, 12'h09C);
    close_frame(6, 1'b1);

    // Reset in the middle of a line, then a line before any newframe
    mode = 2'b00;
    @(negedge clk);
    href = 1'b1;
    send_byte(8'h12);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    href  = 1'b0;
    pclk  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_bank = 1'b0;
    repeat (4) @(negedge clk);
    raw_line(4, 8'h0A, 8'hBC);
    close_frame(6, 1'b0);
    line(4, 8'h0A, 8'hBC, 12'hABC);
    close_frame(6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
